gb_cpu_interrupt_ctrl: RTL and testbench

Parametrised interrupt controller for the gb_cpu core. It generalises the single IME flag with its delayed-EI path into a complete unit containing:
- NUM_IRQ request lines
- IE/IF registers
- fixed-priority selection
- HALT wake-up
- a timed dispatch handshake that yields the service vector

It sits beside the scheduler, which asserts EI/DI/RETI and acknowledges dispatch at instruction boundaries.

---
 rtl/gb_cpu_interrupt_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_gb_cpu_interrupt_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/gb_cpu_interrupt_ctrl.sv
// Purpose: gb_cpu interrupt controller (IE/IF, IME with delayed EI, fixed-priority dispatch, HALT wake).
// Latency: request raised one cycle after IME & pending; dispatch runs DISPATCH_CYCLES cycles after ack.
// Backpressure: int_req_o holds until the scheduler acks or IME drops; acks outside REQ are ignored.
module gb_cpu_interrupt_ctrl #(
  parameter int         NUM_IRQ         = 5,
  parameter logic [7:0] VEC_BASE        = 8'h40,
  parameter logic [7:0] VEC_STRIDE      = 8'h08,
  parameter int         EI_DELAY        = 1,
  parameter int         DISPATCH_CYCLES = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               ie_wr_i,
  input  logic               if_wr_i,
  input  logic [7:0]         wr_data_i,
  output logic [7:0]         ie_o,
  output logic [7:0]         if_o,
  input  logic               ei_i,
  input  logic               di_i,
  input  logic               reti_i,
  input  logic               halted_i,
  output logic               wake_o,
  output logic               int_req_o,
  input  logic               int_ack_i,
  output logic [15:0]        int_vector_o,
  output logic               dispatch_o,
  output logic               dispatch_done_o,
  output logic               ime_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_DISPATCH = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [7:0]           r_ie;
  logic [NUM_IRQ-1:0]   r_if;
  logic                 r_ime;
  logic [1:0]           r_ei_cnt;
  logic [2:0]           r_disp_cnt;
  logic [15:0]          r_vec;

  logic [NUM_IRQ-1:0]   w_pending;
  logic [NUM_IRQ-1:0]   w_ie_eff;
  logic [NUM_IRQ-1:0]   w_if_eff;
  logic [NUM_IRQ-1:0]   w_ack_pend;
  logic [NUM_IRQ-1:0]   w_ack_oh;
  logic [2:0]           w_ack_sel;
  logic                 w_ack_any;
  logic                 w_ack;
  logic                 w_in_disp;
  logic                 w_disp_last;
  logic [7:0]           w_vec_lo;
  logic [NUM_IRQ-1:0]   w_if_nxt;
  logic [7:0]           w_if_rd;
  logic                 w_req;
  logic                 w_unused_halted;

  // HALT is resolved by the scheduler from wake_o; the controller itself never looks at it.
  assign w_unused_halted = halted_i;

  assign w_pending   = r_ie[NUM_IRQ-1:0] & r_if;
  assign w_in_disp   = (r_state == ST_DISPATCH);
  assign w_disp_last = w_in_disp && (r_disp_cnt == 3'(DISPATCH_CYCLES));
  assign w_ack       = (r_state == ST_REQ) && int_ack_i && r_ime && !di_i;

  // The ack sees IE/IF as they will be after a same-cycle write, so a write that
  // empties pending in the ack cycle yields the null vector and clears nothing.
  assign w_ie_eff   = ie_wr_i ? wr_data_i[NUM_IRQ-1:0] : r_ie[NUM_IRQ-1:0];
  assign w_if_eff   = if_wr_i ? wr_data_i[NUM_IRQ-1:0] : r_if;
  assign w_ack_pend = w_ie_eff & w_if_eff;
  assign w_ack_any  = |w_ack_pend;

  // Fixed priority: lowest set index wins, so scan downward and let the last hit stand.
  always_comb begin
    w_ack_sel = 3'd0;
    w_ack_oh  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_ack_pend[i]) begin
        w_ack_sel   = 3'(i);
        w_ack_oh    = '0;
        w_ack_oh[i] = 1'b1;
      end
    end
  end

  // Vector arithmetic deliberately wraps at 8 bits.
  assign w_vec_lo = VEC_BASE + ({5'd0, w_ack_sel} * VEC_STRIDE);

  // IF next value: software write, then ack clear, then hardware sets win last.
  always_comb begin
    w_if_nxt = w_if_eff;
    if (w_ack && w_ack_any) begin
      w_if_nxt = w_if_nxt & ~w_ack_oh;
    end
    w_if_nxt = w_if_nxt | irq_i;
  end

  // Unimplemented IF bits read back as 1.
  always_comb begin
    w_if_rd              = 8'hFF;
    w_if_rd[NUM_IRQ-1:0] = r_if;
  end

  // Next-state and request decode for the dispatch FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_ime && (|w_pending)) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        w_req = 1'b1;
        if (di_i || !r_ime) begin
          w_state_nxt = ST_IDLE;
        end else if (int_ack_i) begin
          w_state_nxt = ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        if (w_disp_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register; reset aborts any dispatch without a done pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Dispatch cycle counter: 1 on the first dispatch cycle, up to DISPATCH_CYCLES.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_disp_cnt <= 3'd0;
    end else if (w_ack) begin
      r_disp_cnt <= 3'd1;
    end else if (w_disp_last) begin
      r_disp_cnt <= 3'd0;
    end else if (w_in_disp) begin
      r_disp_cnt <= r_disp_cnt + 3'd1;
    end
  end

  // Vector captured at ack; null when the pending set emptied in the ack cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_vec <= 16'h0000;
    end else if (w_ack) begin
      r_vec <= w_ack_any ? {8'h00, w_vec_lo} : 16'h0000;
    end
  end

  // IE and IF registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ie <= 8'h00;
      r_if <= '0;
    end else begin
      if (ie_wr_i) begin
        r_ie <= wr_data_i;
      end
      r_if <= w_if_nxt;
    end
  end

  // IME: DI beats everything, ack disarms, EI arms a countdown that does not restart.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ime    <= 1'b0;
      r_ei_cnt <= 2'd0;
    end else if (di_i || w_ack) begin
      r_ime    <= 1'b0;
      r_ei_cnt <= 2'd0;
    end else begin
      if (r_ei_cnt != 2'd0) begin
        if (r_ei_cnt == 2'd1) begin
          r_ime <= 1'b1;
        end
        r_ei_cnt <= r_ei_cnt - 2'd1;
      end else if (ei_i && !w_in_disp) begin
        if (EI_DELAY == 0) begin
          r_ime <= 1'b1;
        end else begin
          r_ei_cnt <= 2'(EI_DELAY);
        end
      end
      if (reti_i && !w_in_disp) begin
        r_ime <= 1'b1;
      end
    end
  end

  assign ie_o            = r_ie;
  assign if_o            = w_if_rd;
  assign wake_o          = |w_pending;
  assign int_req_o       = w_req;
  assign int_vector_o    = r_vec;
  assign dispatch_o      = w_in_disp;
  assign dispatch_done_o = w_disp_last;
  assign ime_o           = r_ime;

endmodule

// File: tb/tb_gb_cpu_interrupt_ctrl.sv
// Purpose: self-checking bench for gb_cpu_interrupt_ctrl (default and 8-source instances).
// Latency: inputs driven 1 time unit after posedge; outputs sampled there or on negedge.
// Backpressure: expected vectors queued at ack, consumed when dispatch_o rises.
module tb_gb_cpu_interrupt_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Instance A: default parameters.
  logic       a_rst, a_ie_wr, a_if_wr, a_ei, a_di, a_reti, a_halt, a_ack;
  logic [4:0] a_irq;
  logic [7:0] a_wdat, a_ie, a_if;
  logic       a_wake, a_req, a_disp, a_done, a_ime;
  logic [15:0] a_vec;

  gb_cpu_interrupt_ctrl dut_a (
    .clk(clk), .reset(a_rst), .irq_i(a_irq), .ie_wr_i(a_ie_wr), .if_wr_i(a_if_wr),
    .wr_data_i(a_wdat), .ie_o(a_ie), .if_o(a_if), .ei_i(a_ei), .di_i(a_di),
    .reti_i(a_reti), .halted_i(a_halt), .wake_o(a_wake), .int_req_o(a_req),
    .int_ack_i(a_ack), .int_vector_o(a_vec), .dispatch_o(a_disp),
    .dispatch_done_o(a_done), .ime_o(a_ime)
  );

  // Instance B: eight sources, wide stride to exercise vector wrap.
  logic       b_rst, b_ie_wr, b_reti, b_ack;
  logic [7:0] b_irq, b_wdat, b_ie, b_if;
  logic       b_wake, b_req, b_disp, b_done, b_ime;
  logic [15:0] b_vec;

  gb_cpu_interrupt_ctrl #(
    .NUM_IRQ(8), .VEC_BASE(8'h40), .VEC_STRIDE(8'h20), .EI_DELAY(1), .DISPATCH_CYCLES(5)
  ) dut_b (
    .clk(clk), .reset(b_rst), .irq_i(b_irq), .ie_wr_i(b_ie_wr), .if_wr_i(1'b0),
    .wr_data_i(b_wdat), .ie_o(b_ie), .if_o(b_if), .ei_i(1'b0), .di_i(1'b0),
    .reti_i(b_reti), .halted_i(1'b0), .wake_o(b_wake), .int_req_o(b_req),
    .int_ack_i(b_ack), .int_vector_o(b_vec), .dispatch_o(b_disp),
    .dispatch_done_o(b_done), .ime_o(b_ime)
  );

  // Scoreboard for instance A: one expected vector per accepted ack.
  logic [15:0] exp_vec_q[$];
  logic [15:0] ev;
  int  dcnt      = 0;
  int  n_disp    = 0;
  int  n_done    = 0;
  bit  prev_disp = 1'b0;
  bit  b_done_seen = 1'b0;

  always @(negedge clk) begin
    if (a_disp && !prev_disp) begin
      dcnt = 1;
      if (exp_vec_q.size() == 0) begin
        check("unexpected_dispatch", 32'd1, 32'd0);
      end else begin
        ev = exp_vec_q.pop_front();
        check("sb_vector", {16'h0, a_vec}, {16'h0, ev});
      end
    end else if (a_disp) begin
      dcnt++;
    end
    if (a_done) begin
      n_done++;
      check("done_cycle", dcnt, 5);
    end
    if (!a_disp && prev_disp) begin
      n_disp++;
      check("dispatch_len", dcnt, 5);
    end
    prev_disp = a_disp;
    if (b_done) b_done_seen = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a_idle();
    for (int i = 0; i < 20 && a_disp; i++) tick();
    check("dispatch_end", a_disp, 0);
  endtask

  bit seen;

  initial begin
    a_rst = 0; a_ie_wr = 1; a_if_wr = 0; a_wdat = 8'hFF; a_ei = 0; a_di = 0;
    a_reti = 0; a_halt = 0; a_ack = 0; a_irq = '0;
    b_rst = 0; b_ie_wr = 1; b_wdat = 8'hFF; b_reti = 0; b_ack = 0; b_irq = '0;
    tick(); tick();
    a_rst = 1; a_ie_wr = 0; a_wdat = 8'h00;
    b_rst = 1; b_ie_wr = 0; b_wdat = 8'h00;
    tick();

    // Reset state, including a write held during reset.
    check("rst_ie", a_ie, 8'h00);
    check("rst_if", a_if, 8'hE0);
    check("rst_ime", a_ime, 0);
    check("rst_req", a_req, 0);
    check("rst_vec", a_vec, 16'h0000);
    check("rst_disp", a_disp, 0);
    check("rst_b_if", b_if, 8'h00);
    check("rst_b_ie", b_ie, 8'h00);

    // Basic dispatch: sources 2 and 4 pending, 2 wins.
    a_ie_wr = 1; a_wdat = 8'h1F; tick(); a_ie_wr = 0;
    check("ie_write", a_ie, 8'h1F);
    a_reti = 1; a_irq = 5'b10100; tick(); a_reti = 0; a_irq = '0;
    check("ime_after_reti", a_ime, 1);
    check("if_after_irq", a_if, 8'hF4);
    tick();
    check("t2_req", a_req, 1);
    a_ack = 1; exp_vec_q.push_back(16'h0050); tick(); a_ack = 0;
    check("t2_vector", a_vec, 16'h0050);
    check("t2_if", a_if, 8'hF0);
    check("t2_ime", a_ime, 0);
    check("t2_disp", a_disp, 1);
    wait_a_idle();
    check("t2_no_req", a_req, 0);
    check("t2_wake", a_wake, 1);

    // EI delay of one m-cycle, then DI drops a live request.
    a_ei = 1; tick(); a_ei = 0;
    check("ei_n1", a_ime, 0);
    tick();
    check("ei_n2", a_ime, 1);
    tick();
    check("t3_req", a_req, 1);
    a_di = 1; tick(); a_di = 0;
    check("di_req_drop", a_req, 0);
    check("di_ime", a_ime, 0);

    // DI one cycle after EI cancels the pending enable.
    a_ei = 1; tick(); a_ei = 0; a_di = 1; tick(); a_di = 0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      seen = seen | a_req | a_ime;
      tick();
    end
    check("ei_cancel", seen, 0);

    // Held EI must not restart the countdown.
    a_ei = 1; tick(); tick(); a_ei = 0;
    check("ei_no_restart", a_ime, 1);
    tick();
    check("t3c_req", a_req, 1);
    a_ack = 1; exp_vec_q.push_back(16'h0060); tick(); a_ack = 0;
    check("t3c_vector", a_vec, 16'h0060);
    check("t3c_if", a_if, 8'hE0);
    wait_a_idle();

    // IF cleared by software in the ack cycle: null vector, dispatch still runs.
    a_reti = 1; a_irq = 5'b00010; tick(); a_reti = 0; a_irq = '0;
    tick();
    check("t4_req", a_req, 1);
    a_if_wr = 1; a_wdat = 8'h00; a_ack = 1; exp_vec_q.push_back(16'h0000); tick();
    a_if_wr = 0; a_ack = 0;
    check("t4_vector", a_vec, 16'h0000);
    check("t4_if", a_if, 8'hE0);
    check("t4_disp", a_disp, 1);
    a_reti = 1; tick(); a_reti = 0;
    check("reti_ignored_in_disp", a_ime, 0);
    wait_a_idle();

    // Hardware set beats the ack clear of the same bit.
    a_reti = 1; a_irq = 5'b00001; tick(); a_reti = 0; a_irq = '0;
    tick();
    check("t5_req", a_req, 1);
    a_ack = 1; a_irq = 5'b00001; exp_vec_q.push_back(16'h0040); tick(); a_ack = 0; a_irq = '0;
    check("t5_if", a_if, 8'hE1);
    check("t5_vector", a_vec, 16'h0040);
    wait_a_idle();
    a_halt = 1; tick();
    check("t5_wake", a_wake, 1);
    check("t5_no_req", a_req, 0);
    check("t5_ime", a_ime, 0);
    a_ack = 1; tick(); a_ack = 0;
    check("ack_ignored_disp", a_disp, 0);
    check("ack_ignored_if", a_if, 8'hE1);
    tick(); tick(); tick();

    // Eight sources, source 7 only: vector wraps; reset in dispatch cycle 3.
    b_ie_wr = 1; b_wdat = 8'hFF; b_irq = 8'h80; b_reti = 1; tick();
    b_ie_wr = 0; b_wdat = 8'h00; b_irq = '0; b_reti = 0;
    check("b_if_set", b_if, 8'h80);
    check("b_ime", b_ime, 1);
    tick();
    check("b_req", b_req, 1);
    b_ack = 1; tick(); b_ack = 0;
    check("b_vector_wrap", b_vec, 16'h0020);
    check("b_disp", b_disp, 1);
    check("b_if_clr", b_if, 8'h00);
    tick(); tick();
    check("b_disp_c3", b_disp, 1);
    b_rst = 0; tick(); b_rst = 1;
    check("b_abort_disp", b_disp, 0);
    check("b_abort_req", b_req, 0);
    check("b_abort_vec", b_vec, 16'h0000);
    check("b_abort_ime", b_ime, 0);
    tick(); tick(); tick();
    check("b_no_done", b_done_seen, 0);

    check("a_dispatch_count", n_disp, 4);
    check("a_done_count", n_done, 4);
    check("sb_empty", exp_vec_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
